// File: rtl/pe_csc_stream_sender.sv
// pe_csc_stream_sender
//
// Streams one CSC operand (address vector, then data vector) from two
// synchronous-read scratch memories into one PE input pair. After each
// stream the block waits for the PE's matching write-finish pulse. A skip
// request (operand already resident in the PE) completes without sending.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, skip           one-cycle request (sampled in IDLE only) and reuse flag
//   addr_base, addr_len   address-vector location and word count
//   data_base, data_len   data-vector location and word count
//   addr_rd_en/addr/data  address-memory read port (data one cycle after en)
//   data_rd_en/addr/data  data-memory read port (data one cycle after en)
//   out_addr_valid/out_addr, out_data_valid/out_data   word streams to the PE
//   addr_write_fin, data_write_fin                     PE "vector stored" pulses
//   busy, done, protocol_err                           status
//
// Handshake: the PE side has no backpressure. A word is transferred on every
// cycle its *_valid is high; the PE acknowledges a complete vector with a
// single-cycle *_write_fin pulse, which is only honoured in the matching
// WAIT state.
module pe_csc_stream_sender #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 13,
  parameter int MEM_AW = 10,
  parameter int LEN_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              skip,
  input  logic [MEM_AW-1:0] addr_base,
  input  logic [LEN_W-1:0]  addr_len,
  input  logic [MEM_AW-1:0] data_base,
  input  logic [LEN_W-1:0]  data_len,
  output logic              addr_rd_en,
  output logic [MEM_AW-1:0] addr_rd_addr,
  input  logic [ADDR_W-1:0] addr_rd_data,
  output logic              data_rd_en,
  output logic [MEM_AW-1:0] data_rd_addr,
  input  logic [DATA_W-1:0] data_rd_data,
  output logic              out_addr_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_data_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              addr_write_fin,
  input  logic              data_write_fin,
  output logic              busy,
  output logic              done,
  output logic              protocol_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_ADDR,
    S_WAIT_ADDR_FIN,
    S_SEND_DATA,
    S_WAIT_DATA_FIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   k_q;
  logic [LEN_W-1:0]   k_inc;
  logic [MEM_AW-1:0]  addr_base_q, data_base_q;
  logic [LEN_W-1:0]   addr_len_q, data_len_q;
  logic               addr_vld_q, data_vld_q;
  logic               addr_fin_q, data_fin_q;
  logic               err_q;
  logic               accept;
  logic               addr_last, data_last;
  logic               addr_fin_seen, data_fin_seen;

  assign accept        = (state_q == S_IDLE) && start;
  assign k_inc         = k_q + LEN_W'(1);
  assign addr_last     = (k_inc == addr_len_q);
  assign data_last     = (k_inc == data_len_q);
  // The WAIT state may leave on the pulse itself, not just the registered flag.
  assign addr_fin_seen = addr_fin_q || addr_write_fin;
  assign data_fin_seen = data_fin_q || data_write_fin;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (skip)                state_d = S_DONE;
          else if (addr_len != '0) state_d = S_SEND_ADDR;
          else if (data_len != '0) state_d = S_SEND_DATA;
          else                     state_d = S_DONE;
        end
      end
      S_SEND_ADDR: begin
        if (addr_last) state_d = S_WAIT_ADDR_FIN;
      end
      S_WAIT_ADDR_FIN: begin
        if (addr_fin_seen) state_d = (data_len_q != '0) ? S_SEND_DATA : S_DONE;
      end
      S_SEND_DATA: begin
        if (data_last) state_d = S_WAIT_DATA_FIN;
      end
      S_WAIT_DATA_FIN: begin
        if (data_fin_seen) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-port and status outputs
  always_comb begin
    addr_rd_en   = (state_q == S_SEND_ADDR);
    data_rd_en   = (state_q == S_SEND_DATA);
    addr_rd_addr = '0;
    data_rd_addr = '0;
    // Address arithmetic wraps at MEM_AW bits.
    if (addr_rd_en) addr_rd_addr = addr_base_q + MEM_AW'(k_q);
    if (data_rd_en) data_rd_addr = data_base_q + MEM_AW'(k_q);
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    protocol_err = err_q;
  end

  // Memory read data is already registered inside the memory; it is passed
  // through and qualified by the delayed read strobe. Gating keeps the words
  // at zero whenever nothing is valid (including after reset).
  assign out_addr_valid = addr_vld_q;
  assign out_data_valid = data_vld_q;
  assign out_addr       = addr_vld_q ? addr_rd_data : '0;
  assign out_data       = data_vld_q ? data_rd_data : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      addr_base_q <= '0;
      data_base_q <= '0;
      addr_len_q  <= '0;
      data_len_q  <= '0;
      addr_vld_q  <= 1'b0;
      data_vld_q  <= 1'b0;
      addr_fin_q  <= 1'b0;
      data_fin_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_vld_q <= addr_rd_en;
      data_vld_q <= data_rd_en;

      // Word index: counts within a SEND state, zero everywhere else.
      if ((state_q == S_SEND_ADDR && !addr_last) ||
          (state_q == S_SEND_DATA && !data_last))
        k_q <= k_inc;
      else
        k_q <= '0;

      if (accept) begin
        addr_base_q <= addr_base;
        data_base_q <= data_base;
        addr_len_q  <= addr_len;
        data_len_q  <= data_len;
      end

      // Fin flags: cleared on entry to the SEND state, set only by a pulse
      // in the WAIT state, so an early pulse never satisfies the wait.
      if (state_q != S_SEND_ADDR && state_d == S_SEND_ADDR)
        addr_fin_q <= 1'b0;
      else if (state_q == S_WAIT_ADDR_FIN && addr_write_fin)
        addr_fin_q <= 1'b1;

      if (state_q != S_SEND_DATA && state_d == S_SEND_DATA)
        data_fin_q <= 1'b0;
      else if (state_q == S_WAIT_DATA_FIN && data_write_fin)
        data_fin_q <= 1'b1;

      // A fin while the stream is still being read arrives before the last
      // valid word, which is always emitted after the SEND state ends.
      if (accept)
        err_q <= 1'b0;
      else if ((state_q == S_SEND_ADDR && addr_write_fin) ||
               (state_q == S_SEND_DATA && data_write_fin))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_csc_stream_sender.sv
// Testbench for pe_csc_stream_sender. Each transaction is turned into a
// per-cycle expected schedule (relative to the start cycle) from the timing
// rules, plus ordered queues of the words each stream must deliver.
module tb_pe_csc_stream_sender;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 13;
  localparam int MEM_AW = 10;
  localparam int LEN_W  = 9;
  localparam int MEM_N  = 1 << MEM_AW;
  localparam int TMAX   = 1024;

  logic              clock;
  logic              reset;
  logic              start;
  logic              skip;
  logic [MEM_AW-1:0] addr_base;
  logic [LEN_W-1:0]  addr_len;
  logic [MEM_AW-1:0] data_base;
  logic [LEN_W-1:0]  data_len;
  logic              addr_rd_en;
  logic [MEM_AW-1:0] addr_rd_addr;
  logic [ADDR_W-1:0] addr_rd_data;
  logic              data_rd_en;
  logic [MEM_AW-1:0] data_rd_addr;
  logic [DATA_W-1:0] data_rd_data;
  logic              out_addr_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              out_data_valid;
  logic [DATA_W-1:0] out_data;
  logic              addr_write_fin;
  logic              data_write_fin;
  logic              busy;
  logic              done;
  logic              protocol_err;

  pe_csc_stream_sender #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .LEN_W(LEN_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .skip(skip),
    .addr_base(addr_base), .addr_len(addr_len),
    .data_base(data_base), .data_len(data_len),
    .addr_rd_en(addr_rd_en), .addr_rd_addr(addr_rd_addr), .addr_rd_data(addr_rd_data),
    .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
    .out_addr_valid(out_addr_valid), .out_addr(out_addr),
    .out_data_valid(out_data_valid), .out_data(out_data),
    .addr_write_fin(addr_write_fin), .data_write_fin(data_write_fin),
    .busy(busy), .done(done), .protocol_err(protocol_err)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scratch memories ----------------
  logic [ADDR_W-1:0] amem [0:MEM_N-1];
  logic [DATA_W-1:0] dmem [0:MEM_N-1];

  always @(posedge clock) begin
    if (addr_rd_en) addr_rd_data <= amem[addr_rd_addr];
    if (data_rd_en) data_rd_data <= dmem[data_rd_addr];
  end

  // ---------------- expected schedule ----------------
  bit                exp_are  [0:TMAX-1];
  bit                exp_dre  [0:TMAX-1];
  bit                exp_av   [0:TMAX-1];
  bit                exp_dv   [0:TMAX-1];
  bit                exp_busy [0:TMAX-1];
  bit                exp_done [0:TMAX-1];
  bit                exp_err  [0:TMAX-1];
  logic [MEM_AW-1:0] exp_ara  [0:TMAX-1];
  logic [MEM_AW-1:0] exp_dra  [0:TMAX-1];
  bit                drv_start[0:TMAX-1];
  bit                drv_afin [0:TMAX-1];
  bit                drv_dfin [0:TMAX-1];
  bit                drv_rst  [0:TMAX-1];
  logic [ADDR_W-1:0] exp_aw_q[$];
  logic [DATA_W-1:0] exp_dw_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int rel      = 0;
  int last_t   = 0;
  bit chk_on   = 1'b0;
  bit err_model = 1'b0;

  bit                cur_skip;
  logic [MEM_AW-1:0] cur_ab, cur_db;
  logic [LEN_W-1:0]  cur_an, cur_dn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, rel, act, exp);
    end
  endtask

  // Build the expected schedule for one request accepted at relative cycle 0.
  // wa/wd: extra wait cycles before the real fin. ea/ed: 1-based word slot
  // of an early fin during the read phase (0 = none). spur: spurious start.
  task automatic build(input bit sk, input int ab, input int an, input int db,
                       input int dn, input int wa, input int wd, input int ea,
                       input int ed, input int spur);
    int c;
    int ae;
    int de;
    int f;
    for (int t = 0; t < TMAX; t++) begin
      exp_are[t] = 0; exp_dre[t] = 0; exp_av[t] = 0; exp_dv[t] = 0;
      exp_busy[t] = 0; exp_done[t] = 0; exp_err[t] = 0;
      exp_ara[t] = '0; exp_dra[t] = '0;
      drv_start[t] = 0; drv_afin[t] = 0; drv_dfin[t] = 0; drv_rst[t] = 0;
    end
    exp_aw_q.delete();
    exp_dw_q.delete();
    cur_skip = sk;
    cur_ab = MEM_AW'(ab); cur_db = MEM_AW'(db);
    cur_an = LEN_W'(an);  cur_dn = LEN_W'(dn);
    c = 1; ae = -1; de = -1;
    if (!sk) begin
      if (an > 0) begin
        for (int k = 0; k < an; k++) begin
          exp_are[c+k] = 1;
          exp_ara[c+k] = MEM_AW'((ab + k) % MEM_N);
          exp_av[c+k+1] = 1;
          exp_aw_q.push_back(amem[(ab + k) % MEM_N]);
        end
        if (ea > 0) begin ae = c + ea - 1; drv_afin[ae] = 1; end
        f = c + an + wa;
        drv_afin[f] = 1;
        c = f + 1;
      end
      if (dn > 0) begin
        for (int k = 0; k < dn; k++) begin
          exp_dre[c+k] = 1;
          exp_dra[c+k] = MEM_AW'((db + k) % MEM_N);
          exp_dv[c+k+1] = 1;
          exp_dw_q.push_back(dmem[(db + k) % MEM_N]);
        end
        if (ed > 0) begin de = c + ed - 1; drv_dfin[de] = 1; end
        f = c + dn + wd;
        drv_dfin[f] = 1;
        c = f + 1;
      end
    end
    exp_done[c] = 1;
    for (int t = 1; t <= c; t++) exp_busy[t] = 1;
    last_t = c + 2;
    exp_err[0] = err_model;
    for (int t = 1; t <= last_t; t++)
      exp_err[t] = (ae >= 0 && t > ae) || (de >= 0 && t > de);
    err_model = exp_err[last_t];
    drv_start[0] = 1;
    // Ignored requests: a start while busy, fins in IDLE and in DONE.
    if (spur > 0 && c > 1) drv_start[1 + spur % (c - 1)] = 1;
    if (spur % 2 == 1) begin
      drv_afin[c] = 1; drv_dfin[c] = 1;
      drv_afin[0] = 1; drv_dfin[0] = 1;
    end
  endtask

  task automatic run_txn();
    chk_on = 1'b1;
    for (int t = 0; t <= last_t; t++) begin
      rel            = t;
      start          = drv_start[t];
      skip           = cur_skip;
      addr_base      = cur_ab;
      addr_len       = cur_an;
      data_base      = cur_db;
      data_len       = cur_dn;
      addr_write_fin = drv_afin[t];
      data_write_fin = drv_dfin[t];
      reset          = drv_rst[t];
      @(posedge clock);
      #1;
    end
    chk_on = 1'b0;
    start = 1'b0; addr_write_fin = 1'b0; data_write_fin = 1'b0; reset = 1'b0;
    chk("addr_words_left", exp_aw_q.size(), 0);
    chk("data_words_left", exp_dw_q.size(), 0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_on) begin
      chk("busy", busy, exp_busy[rel]);
      chk("done", done, exp_done[rel]);
      chk("protocol_err", protocol_err, exp_err[rel]);
      chk("addr_rd_en", addr_rd_en, exp_are[rel]);
      chk("data_rd_en", data_rd_en, exp_dre[rel]);
      if (exp_are[rel]) chk("addr_rd_addr", addr_rd_addr, exp_ara[rel]);
      if (exp_dre[rel]) chk("data_rd_addr", data_rd_addr, exp_dra[rel]);
      chk("out_addr_valid", out_addr_valid, exp_av[rel]);
      chk("out_data_valid", out_data_valid, exp_dv[rel]);
      chk("one_stream", out_addr_valid & out_data_valid, 0);
      if (out_addr_valid) begin
        if (exp_aw_q.size() == 0) chk("addr_extra_word", 1, 0);
        else chk("out_addr", out_addr, exp_aw_q.pop_front());
      end
      if (out_data_valid) begin
        if (exp_dw_q.size() == 0) chk("data_extra_word", 1, 0);
        else chk("out_data", out_data, exp_dw_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < MEM_N; i++) begin
      amem[i] = ADDR_W'($urandom);
      dmem[i] = DATA_W'($urandom);
    end
    reset = 1'b1; start = 1'b0; skip = 1'b0;
    addr_base = '0; addr_len = '0; data_base = '0; data_len = '0;
    addr_write_fin = 1'b0; data_write_fin = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", protocol_err, 0);
    chk("rst_addr_rd_en", addr_rd_en, 0);
    chk("rst_data_rd_en", data_rd_en, 0);
    chk("rst_addr_rd_addr", addr_rd_addr, 0);
    chk("rst_data_rd_addr", data_rd_addr, 0);
    chk("rst_addr_valid", out_addr_valid, 0);
    chk("rst_data_valid", out_data_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed: addr fin at cycle 8, data fin at cycle 16.
    build(0, 'h10, 3, 'h20, 4, 4, 3, 0, 0, 0);
    chk("model_av2", exp_av[2], 1);
    chk("model_av5", exp_av[5], 0);
    chk("model_afin8", drv_afin[8], 1);
    chk("model_dra9", exp_dra[9], 'h20);
    chk("model_dv13", exp_dv[13], 1);
    chk("model_dv14", exp_dv[14], 0);
    chk("model_done17", exp_done[17], 1);
    run_txn();

    // Skip: done at cycle 1, busy for exactly one cycle.
    build(1, 'h55, 6, 'h66, 6, 0, 0, 0, 0, 1);
    chk("model_skip_done1", exp_done[1], 1);
    chk("model_skip_busy2", exp_busy[2], 0);
    run_txn();

    // Empty address vector.
    build(0, 'h40, 0, 'h30, 2, 0, 1, 0, 0, 2);
    run_txn();

    // Early addr fin at cycle 2, then a clearing start.
    build(0, 'h00, 5, 'h80, 3, 2, 0, 2, 0, 0);
    chk("model_err3", exp_err[3], 1);
    run_txn();
    build(0, 'h90, 2, 'hA0, 2, 0, 0, 0, 0, 0);
    chk("model_err_clear", exp_err[1], 0);
    run_txn();

    // Address wrap.
    build(0, 'h3FE, 4, 'h3FF, 3, 1, 1, 0, 0, 3);
    chk("model_wrap", exp_ara[3], 'h000);
    run_txn();

    // Reset during the third SEND_DATA cycle (data reads start at cycle 5).
    build(0, 'h100, 2, 'h200, 6, 1, 0, 0, 0, 0);
    drv_rst[7] = 1;
    for (int t = 8; t < TMAX; t++) begin
      exp_are[t] = 0; exp_dre[t] = 0; exp_av[t] = 0; exp_dv[t] = 0;
      exp_busy[t] = 0; exp_done[t] = 0; exp_err[t] = 0;
      drv_afin[t] = 0; drv_dfin[t] = 0; drv_start[t] = 0;
    end
    last_t = 11;
    err_model = 1'b0;
    // Only the words valid in cycles 6 and 7 reach the PE.
    while (exp_dw_q.size() > 2) void'(exp_dw_q.pop_back());
    run_txn();

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      int an, dn;
      an = $urandom_range(0, 20);
      dn = $urandom_range(0, 20);
      build($urandom_range(0, 7) == 0, $urandom_range(0, MEM_N - 1), an,
            $urandom_range(0, MEM_N - 1), dn,
            $urandom_range(0, 4), $urandom_range(0, 4),
            ($urandom_range(0, 3) == 0 && an > 0) ? $urandom_range(1, an) : 0,
            ($urandom_range(0, 3) == 0 && dn > 0) ? $urandom_range(1, dn) : 0,
            $urandom_range(0, 9));
      run_txn();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
